// File: rtl/operand_loader.sv
// Captures two switch operands via a debounced enter button, writes them plus a command word into dmem, waits for the processor, then clears the mailbox.
// States: GET_A=0 wait A | GET_B=1 wait B | WR_A=2 | WR_B=3 | WR_CMD=4 | WAIT_DONE=5 | DONE=6 wait ack press | WR_CLR=7 clear mailbox.
module operand_loader #(
  parameter logic [31:0] ADDR_A          = 32'h0000_0100,
  parameter logic [31:0] ADDR_B          = 32'h0000_0104,
  parameter logic [31:0] ADDR_CMD        = 32'h0000_0108,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          TIMEOUT_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  SW_DATA,
  input  logic        SW_ENTER,
  input  logic        cpu_we,
  input  logic        proc_done,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        timeout_err,
  output logic [2:0]  phase
);

  localparam int LW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    GET_B     = 3'd1,
    WR_A      = 3'd2,
    WR_B      = 3'd3,
    WR_CMD    = 3'd4,
    WAIT_DONE = 3'd5,
    DONE      = 3'd6,
    WR_CLR    = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          edge_q, edge_d;
  logic [1:0]    sync_vld_q, sync_vld_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          press_q, press_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    opa_q, opa_d;
  logic [7:0]    opb_q, opb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          terr_q, terr_d;
  logic          rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= GET_A;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b1;
      sync_vld_q <= 2'b00;
      lock_q     <= '0;
      press_q    <= 1'b0;
      cap_q      <= 8'h00;
      opa_q      <= 8'h00;
      opb_q      <= 8'h00;
      tmo_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      sync_vld_q <= sync_vld_d;
      lock_q     <= lock_d;
      press_q    <= press_d;
      cap_q      <= cap_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      tmo_q      <= tmo_d;
      terr_q     <= terr_d;
    end
  end

  // Edge history is pinned high until the synchronizer holds real samples,
  // so a button held through reset release never looks like a press.
  always_comb begin
    sync1_d    = SW_ENTER;
    sync2_d    = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    edge_d     = sync_vld_q[1] ? sync2_q : 1'b1;
    rise       = sync2_q & ~edge_q;
    press_d    = rise && (lock_q == '0);
    cap_d      = press_d ? SW_DATA : cap_q;
    if (press_d)
      lock_d = LOCK_LOAD;
    else if (lock_q != '0)
      lock_d = lock_q - 1'b1;
    else
      lock_d = lock_q;
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    tmo_d   = tmo_q;
    terr_d  = terr_q;
    wr_en   = 1'b0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
    busy    = 1'b0;
    case (state_q)
      GET_A: begin
        if (press_q) begin
          opa_d   = cap_q;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (press_q) begin
          opb_d   = cap_q;
          state_d = WR_A;
        end
      end
      WR_A: begin
        busy = 1'b1;
        if (!cpu_we) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_A;
          wr_data = {24'h0, opa_q};
          state_d = WR_B;
        end
      end
      WR_B: begin
        busy = 1'b1;
        if (!cpu_we) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_B;
          wr_data = {24'h0, opb_q};
          state_d = WR_CMD;
        end
      end
      WR_CMD: begin
        busy = 1'b1;
        if (!cpu_we) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_CMD;
          wr_data = 32'h1;
          tmo_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (proc_done) begin
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        if (press_q) begin
          terr_d  = 1'b0;
          state_d = WR_CLR;
        end
      end
      WR_CLR: begin
        if (!cpu_we) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_CMD;
          wr_data = 32'h0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  assign phase       = state_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: write ordering, cpu_we stalls, debounce, timeout and reset behaviour.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  SW_DATA;
  logic        SW_ENTER;
  logic        cpu_we;
  logic        proc_done;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t5, t6;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  operand_loader #(
    .DEBOUNCE_CYCLES(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .SW_DATA(SW_DATA),
    .SW_ENTER(SW_ENTER),
    .cpu_we(cpu_we),
    .proc_done(proc_done),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .timeout_err(timeout_err),
    .phase(phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
    if (cpu_we) check_eq("we_collide", 64'(wr_en), 64'd0);
    if (!wr_en) check_eq("idle_bus", {wr_addr, wr_data}, 64'd0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] d);
    SW_DATA  = d;
    SW_ENTER = 1'b1;
    idle(3);
    SW_ENTER = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] target, input int max_cyc);
    int n = 0;
    while (phase !== target && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("wait_phase", 64'(phase), 64'(target));
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic chk_write(input int i, input logic [31:0] a, input logic [31:0] d);
    check_eq($sformatf("wr%0d_addr", i), 64'(log_addr[i]), 64'(a));
    check_eq($sformatf("wr%0d_data", i), 64'(log_data[i]), 64'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    SW_DATA   = 8'h00;
    SW_ENTER  = 1'b0;
    cpu_we    = 1'b0;
    proc_done = 1'b0;
    #2;
    check_eq("rst_phase", 64'(phase), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_terr", 64'(timeout_err), 64'd0);
    idle(3);
    reset = 1'b0;
    idle(3);

    // basic sequence, back-to-back writes, operands immune to later switch changes
    press(8'h2A);
    wait_phase(3'd1, 5);
    idle(20);
    clear_log();
    press(8'h05);
    SW_DATA = 8'hEE;
    wait_phase(3'd5, 10);
    check_eq("seq1_busy", 64'(busy), 64'd1);
    check_eq("seq1_nwr", 64'(log_addr.size()), 64'd3);
    chk_write(0, 32'h100, 32'h2A);
    chk_write(1, 32'h104, 32'h05);
    chk_write(2, 32'h108, 32'h1);
    check_eq("seq1_gap0", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
    check_eq("seq1_gap1", 64'(log_cyc[2] - log_cyc[1]), 64'd1);
    proc_done = 1'b1;
    wait_phase(3'd6, 3);
    proc_done = 1'b0;
    check_eq("done_busy", 64'(busy), 64'd0);
    check_eq("done_terr", 64'(timeout_err), 64'd0);
    idle(20);
    clear_log();
    press(8'h00);
    wait_phase(3'd7, 5);
    wait_phase(3'd0, 5);
    check_eq("clr_nwr", 64'(log_addr.size()), 64'd1);
    chk_write(0, 32'h108, 32'h0);

    // cpu_we stall in WR_B, then timeout with a discarded press in WAIT_DONE
    idle(20);
    press(8'h11);
    wait_phase(3'd1, 5);
    idle(20);
    clear_log();
    press(8'h22);
    wait_phase(3'd3, 5);
    cpu_we = 1'b1;
    idle(4);
    cpu_we = 1'b0;
    wait_phase(3'd5, 5);
    t5 = cyc;
    check_eq("stall_nwr", 64'(log_addr.size()), 64'd3);
    chk_write(0, 32'h100, 32'h11);
    chk_write(1, 32'h104, 32'h22);
    chk_write(2, 32'h108, 32'h1);
    check_eq("stall_gap0", 64'(log_cyc[1] - log_cyc[0]), 64'd5);
    check_eq("stall_gap1", 64'(log_cyc[2] - log_cyc[1]), 64'd1);
    press(8'h99);
    wait_phase(3'd6, 10);
    t6 = cyc;
    check_eq("tmo_len", 64'(t6 - t5), 64'd8);
    check_eq("tmo_terr", 64'(timeout_err), 64'd1);
    proc_done = 1'b1;
    idle(20);
    proc_done = 1'b0;
    check_eq("tmo_hold_phase", 64'(phase), 64'd6);
    check_eq("tmo_hold_terr", 64'(timeout_err), 64'd1);
    clear_log();
    press(8'h00);
    wait_phase(3'd7, 5);
    check_eq("tmo_clr_terr", 64'(timeout_err), 64'd0);
    wait_phase(3'd0, 5);
    check_eq("tmo_clr_nwr", 64'(log_addr.size()), 64'd1);
    chk_write(0, 32'h108, 32'h0);

    // bounce yields one press; proc_done coinciding with timeout wins
    idle(20);
    SW_DATA = 8'h33;
    for (int i = 0; i < 5; i++) begin
      SW_ENTER = (i % 2 == 0);
      idle(2);
    end
    SW_ENTER = 1'b0;
    idle(25);
    check_eq("bounce_phase", 64'(phase), 64'd1);
    clear_log();
    press(8'h44);
    wait_phase(3'd5, 10);
    t5 = cyc;
    idle(7);
    proc_done = 1'b1;
    wait_phase(3'd6, 2);
    proc_done = 1'b0;
    check_eq("tie_len", 64'(cyc - t5), 64'd8);
    check_eq("tie_terr", 64'(timeout_err), 64'd0);
    check_eq("bounce_nwr", 64'(log_addr.size()), 64'd3);
    chk_write(0, 32'h100, 32'h33);
    chk_write(1, 32'h104, 32'h44);
    idle(20);
    press(8'h00);
    wait_phase(3'd0, 10);

    // proc_done outside WAIT_DONE is ignored
    proc_done = 1'b1;
    idle(5);
    check_eq("pd_idle_phase", 64'(phase), 64'd0);
    check_eq("pd_idle_busy", 64'(busy), 64'd0);
    proc_done = 1'b0;

    // reset during WR_B aborts the sequence
    idle(20);
    press(8'h55);
    wait_phase(3'd1, 5);
    idle(20);
    clear_log();
    press(8'h66);
    wait_phase(3'd3, 5);
    reset = 1'b1;
    #1;
    check_eq("abort_wr_en", 64'(wr_en), 64'd0);
    check_eq("abort_phase", 64'(phase), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    idle(2);
    reset = 1'b0;
    idle(20);
    check_eq("abort_nwr", 64'(log_addr.size()), 64'd1);
    chk_write(0, 32'h100, 32'h55);

    // enter held through reset release is not a press
    SW_ENTER = 1'b1;
    reset    = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(10);
    check_eq("held_phase", 64'(phase), 64'd0);
    SW_ENTER = 1'b0;
    idle(5);
    press(8'h77);
    wait_phase(3'd1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 ADDR_A, 32'h0000_0100, dmem word address of operand A.
REQ-002 ADDR_B, 32'h0000_0104, dmem word address of operand B.
REQ-003 ADDR_CMD, 32'h0000_0108, dmem word address of command mailbox.
REQ-004 DEBOUNCE_CYCLES, 16, enter-button lockout length in clk cycles (>=1).
REQ-005 TIMEOUT_CYCLES, 4096, max cycles waiting for proc_done (>=2).
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 SW_DATA  in  8  operand value from board switches, quasi-static.
REQ-009 SW_ENTER  in  1  asynchronous enter button, level, active-high.
REQ-010 cpu_we  in  1  processor MemWrite; processor owns dmem write port when high.
REQ-011 proc_done  in  1  level, high when processor has stored all results.
REQ-012 wr_en  out  1  dmem write strobe from this block, one cycle per word.
REQ-013 wr_addr  out  32  dmem write address, valid when wr_en high.
REQ-014 wr_data  out  32  dmem write data, valid when wr_en high.
REQ-015 busy  out  1  high in states WR_A through WAIT_DONE.
REQ-016 timeout_err  out  1  sticky flag, processor failed to finish in time.
REQ-017 phase  out  3  current state encoding per REQ-021, for LEDs.

Function
REQ-018 SW_ENTER SHALL pass through a 2-flop synchronizer; press = synchronized rising edge.
REQ-019 Press SHALL be accepted only when lockout counter is 0; acceptance loads counter with DEBOUNCE_CYCLES; counter decrements to 0, ignoring presses meanwhile.
REQ-020 Accepted press SHALL be a 1-cycle internal pulse, usable by FSM the cycle after the synchronized edge.
REQ-021 States/encodings: GET_A=0, GET_B=1, WR_A=2, WR_B=3, WR_CMD=4, WAIT_DONE=5, DONE=6, WR_CLR=7.
REQ-022 GET_A: on accepted press, opA <= {24'b0, SW_DATA}; -> GET_B.
REQ-023 GET_B: on accepted press, opB <= {24'b0, SW_DATA}; -> WR_A.
REQ-024 WR_A/WR_B/WR_CMD/WR_CLR: if cpu_we=0, assert wr_en one cycle with (ADDR_A,opA)/(ADDR_B,opB)/(ADDR_CMD,32'h1)/(ADDR_CMD,32'h0), advance to WR_B/WR_CMD/WAIT_DONE/GET_A respectively.
REQ-025 In any WR_* state with cpu_we=1: wr_en=0, remain in state, no write lost or duplicated.
REQ-026 wr_en SHALL be combinational of state and cpu_we; never high when cpu_we high or outside WR_* states.
REQ-027 wr_addr/wr_data SHALL be 0 whenever wr_en=0.
REQ-028 WAIT_DONE: timeout counter cleared on entry, increments each cycle; proc_done=1 -> DONE; counter reaching TIMEOUT_CYCLES-1 without proc_done -> DONE with timeout_err set.
REQ-029 proc_done and timeout in same cycle: proc_done wins, timeout_err unchanged.
REQ-030 DONE: on accepted press -> WR_CLR; timeout_err cleared on that transition.
REQ-031 Presses in WR_A..WAIT_DONE and WR_CLR SHALL be discarded, not queued.
REQ-032 proc_done outside WAIT_DONE SHALL be ignored.
REQ-033 SW_DATA changes after a press SHALL not alter captured operands.
REQ-034 Minimum latency, GET_B press to CMD write with cpu_we=0: 3 cycles (WR_A, WR_B, WR_CMD back-to-back).

Reset
REQ-035 reset SHALL force immediately: state GET_A, opA=opB=0, lockout=0, synchronizer flops 0, timeout counter 0, wr_en=0, wr_addr=wr_data=0, busy=0, timeout_err=0, phase=0.
REQ-036 reset mid-sequence (any WR_* or WAIT_DONE) SHALL abort with no further writes; mailbox not cleared by this block.
REQ-037 SW_ENTER held high through reset release SHALL not generate a press until released and re-pressed.

Verification
REQ-038 SW_DATA=8'h2A press, SW_DATA=8'h05 press, cpu_we=0 -> writes (0x100,0x2A),(0x104,0x05),(0x108,1) on 3 consecutive cycles; phase=5, busy=1.
REQ-039 Same, cpu_we high 4 cycles during WR_B -> exactly 3 writes total, WR_B write delayed 4 cycles, order preserved.
REQ-040 Button bounce 1-0-1-0-1 within DEBOUNCE_CYCLES -> single accepted press, only opA captured, phase=1.
REQ-041 In WAIT_DONE raise proc_done -> phase=6, busy=0; press -> write (0x108,0) then phase=0.
REQ-042 proc_done held 0, TIMEOUT_CYCLES=8 -> DONE after 8 cycles in WAIT_DONE, timeout_err=1; press clears it and writes mailbox 0.
REQ-043 Assert reset during WR_B -> wr_en low same cycle, phase=0, no CMD write after release.
